// File: rtl/alu_out_capture.sv
// Multi-channel alu_out result capture: per-channel timestamped FIFOs drained
// round-robin onto a single valid/ready stream, with a saturating drop counter.
module alu_out_capture #(
    parameter int NUM_CH               = 4,
    parameter int ALU_OUT_RESULT_WIDTH = 16,
    parameter int DEPTH                = 4,
    parameter int TS_WIDTH             = 16,
    parameter int CNT_WIDTH            = 8,
    parameter int EDGE_MODE            = 0,
    localparam int CH_W                = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic                                   flush,
    input  logic [NUM_CH-1:0]                      done,
    input  logic [NUM_CH*ALU_OUT_RESULT_WIDTH-1:0] result,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ALU_OUT_RESULT_WIDTH-1:0]        out_result,
    output logic [CH_W-1:0]                        out_channel,
    output logic [TS_WIDTH-1:0]                    out_timestamp,
    output logic [NUM_CH-1:0]                      ch_empty,
    output logic [CNT_WIDTH-1:0]                   overflow_count
);

    localparam int W       = ALU_OUT_RESULT_WIDTH;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int ENTRY_W = W + TS_WIDTH;
    localparam int SUM_W   = CNT_WIDTH + CH_W + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [TS_WIDTH-1:0]  ts_q, ts_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic [CH_W-1:0]      rr_q, rr_d;
    logic [CNT_WIDTH-1:0] overflow_q, overflow_d;
    logic                 out_valid_q, out_valid_d;
    logic [W-1:0]         out_result_q, out_result_d;
    logic [CH_W-1:0]      out_channel_q, out_channel_d;
    logic [TS_WIDTH-1:0]  out_timestamp_q, out_timestamp_d;

    logic [ENTRY_W-1:0]   mem_q [NUM_CH][DEPTH];
    logic [ENTRY_W-1:0]   mem_d [NUM_CH][DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]     wr_ptr_d [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]     rd_ptr_d [NUM_CH];
    logic [OCC_W-1:0]     occ_q [NUM_CH];
    logic [OCC_W-1:0]     occ_d [NUM_CH];

    logic                 load;
    logic                 found;
    logic                 take;
    logic [CH_W-1:0]      grant;
    logic [CH_W-1:0]      scan_idx;
    int                   scan_sum;
    logic [NUM_CH-1:0]    qualify;
    logic [NUM_CH-1:0]    push;
    logic [NUM_CH-1:0]    pop;
    logic [NUM_CH-1:0]    drop;
    logic [SUM_W-1:0]     drop_cnt;
    logic [SUM_W-1:0]     ovf_sum;

    always_comb begin
        ts_d            = ts_q + TS_WIDTH'(1);
        done_d          = done;
        rr_d            = rr_q;
        overflow_d      = overflow_q;
        out_valid_d     = out_valid_q;
        out_result_d    = out_result_q;
        out_channel_d   = out_channel_q;
        out_timestamp_d = out_timestamp_q;
        mem_d           = mem_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        occ_d           = occ_q;
        load            = !out_valid_q || out_ready;
        found           = 1'b0;
        grant           = '0;
        scan_idx        = '0;
        scan_sum        = 0;
        qualify         = '0;
        push            = '0;
        pop             = '0;
        drop            = '0;
        drop_cnt        = '0;

        // Round-robin scan starting at the pointer, wrapping past the last channel
        for (int j = 0; j < NUM_CH; j++) begin
            scan_sum = int'(rr_q) + j;
            if (scan_sum >= NUM_CH) begin
                scan_sum = scan_sum - NUM_CH;
            end
            scan_idx = CH_W'(scan_sum);
            if (!found && (occ_q[scan_idx] != '0)) begin
                found = 1'b1;
                grant = scan_idx;
            end
        end
        take = !flush && load && found;

        for (int i = 0; i < NUM_CH; i++) begin
            qualify[i] = enable && done[i] && ((EDGE_MODE == 0) || !done_q[i]);
            pop[i]     = take && (grant == CH_W'(i));
            push[i]    = !flush && qualify[i] && ((occ_q[i] != OCC_W'(DEPTH)) || pop[i]);
            drop[i]    = !flush && qualify[i] && !push[i];
            drop_cnt   = drop_cnt + SUM_W'(drop[i]);
            if (flush) begin
                wr_ptr_d[i] = '0;
                rd_ptr_d[i] = '0;
                occ_d[i]    = '0;
            end else begin
                if (push[i]) begin
                    mem_d[i][wr_ptr_q[i]] = {result[i*W +: W], ts_q};
                    wr_ptr_d[i]           = wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
                end
                occ_d[i] = occ_q[i] + OCC_W'(push[i]) - OCC_W'(pop[i]);
            end
        end

        ovf_sum = SUM_W'(overflow_q) + drop_cnt;
        if (ovf_sum > SUM_W'(CNT_MAX)) begin
            overflow_d = CNT_MAX;
        end else begin
            overflow_d = ovf_sum[CNT_WIDTH-1:0];
        end

        // Flush drops the valid flag but leaves the last word visible on out_*
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            out_valid_d = found;
            if (found) begin
                {out_result_d, out_timestamp_d} = mem_q[grant][rd_ptr_q[grant]];
                out_channel_d                   = grant;
                rr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q            <= '0;
            done_q          <= '0;
            rr_q            <= '0;
            overflow_q      <= '0;
            out_valid_q     <= 1'b0;
            out_result_q    <= '0;
            out_channel_q   <= '0;
            out_timestamp_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                occ_q[i]    <= '0;
            end
        end else begin
            ts_q            <= ts_d;
            done_q          <= done_d;
            rr_q            <= rr_d;
            overflow_q      <= overflow_d;
            out_valid_q     <= out_valid_d;
            out_result_q    <= out_result_d;
            out_channel_q   <= out_channel_d;
            out_timestamp_q <= out_timestamp_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            occ_q           <= occ_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i] = (occ_q[i] == '0);
        end
    end

    assign out_valid      = out_valid_q;
    assign out_result     = out_result_q;
    assign out_channel    = out_channel_q;
    assign out_timestamp  = out_timestamp_q;
    assign overflow_count = overflow_q;

endmodule
